// File: rtl/mfunc_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mfunc_reg_pkg
//  Description : Shared offsets and helpers for the MFUNC register sub-bank.
//                Offsets are byte addresses relative to the sub-bank base.
//                  CTRL_BASE      : first RW control register (stride 4)
//                  STAT_BASE      : first RO status register  (stride 4)
//                  EVT_STICKY_OFS : sticky event register (RO / W1C)
//                  EVT_EN_OFS     : event interrupt enable register (RW)
//                  EVT_RAW_OFS    : synchronised event levels (RO)
//  Revision    : 1.0  initial release
// ============================================================================
package mfunc_reg_pkg;

    localparam int unsigned CTRL_BASE      = 32'h000;
    localparam int unsigned STAT_BASE      = 32'h020;
    localparam int unsigned EVT_STICKY_OFS = 32'h040;
    localparam int unsigned EVT_EN_OFS     = 32'h044;
    localparam int unsigned EVT_RAW_OFS    = 32'h048;

    // One byte lane of a byte-enabled write: take the new byte when enabled.
    function automatic logic [7:0] be_merge(input logic [7:0] old_v,
                                            input logic [7:0] new_v,
                                            input logic       be);
        return be ? new_v : old_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mfunc_evt_sync.sv
`default_nettype none
// ============================================================================
//  Module      : mfunc_evt_sync
//  Description : Multi-flop synchroniser for asynchronous event levels with a
//                rising-edge pulse output.
//  Ports       : clk, rst_n (async, active-low)
//                evt_in   [NUM_EVT] asynchronous event levels
//                evt_lvl  [NUM_EVT] synchronised levels
//                evt_rise [NUM_EVT] one-cycle pulse on a synchronised rise
//  Revision    : 1.0  initial release
// ============================================================================
module mfunc_evt_sync #(
    parameter int NUM_EVT  = 8,
    parameter int SYNC_STG = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EVT-1:0] evt_in,
    output logic [NUM_EVT-1:0] evt_lvl,
    output logic [NUM_EVT-1:0] evt_rise
);

    logic [NUM_EVT-1:0] r_sync [SYNC_STG];
    logic [NUM_EVT-1:0] r_prev;
    // Shifts in ones after reset; the top bit means r_prev holds a real
    // sample, so a level already high at reset release is not seen as a rise.
    logic [SYNC_STG:0]  r_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STG; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
            r_fill <= '0;
        end else begin
            r_sync[0] <= evt_in;
            for (int s = 1; s < SYNC_STG; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STG-1];
            r_fill <= {r_fill[SYNC_STG-1:0], 1'b1};
        end
    end

    assign evt_lvl  = r_sync[SYNC_STG-1];
    assign evt_rise = r_fill[SYNC_STG] ? (evt_lvl & ~r_prev) : '0;

endmodule
`default_nettype wire

// File: rtl/mfunc_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mfunc_reg_bank
//  Description : Parametrised MFUNC register sub-bank: NUM_CTRL RW control
//                registers, NUM_STAT RO status captures, sticky event
//                register (W1C) with enable and level interrupt.
//  Ports       : clk, rst_n (async, active-low)
//                wr_en, wr_be, addr, wr_data   write port (addr shared)
//                rd_en -> rd_data, rd_valid, rd_err one cycle later
//                wr_err   pulse for writes to unmapped / read-only offsets
//                ctrl_out control register contents, ctrl i at [i*DW +: DW]
//                stat_in  status inputs (clk domain), evt_in async events
//                irq      registered |(sticky & enable)
//  Revision    : 1.0  initial release
// ============================================================================
module mfunc_reg_bank
    import mfunc_reg_pkg::*;
#(
    parameter int                       DW       = 32,
    parameter int                       AW       = 12,
    parameter int                       NUM_CTRL = 4,
    parameter int                       NUM_STAT = 2,
    parameter int                       NUM_EVT  = 8,
    parameter int                       SYNC_STG = 2,
    parameter logic [NUM_CTRL*DW-1:0]   CTRL_RST = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DW/8-1:0]          wr_be,
    input  logic [AW-1:0]            addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     rd_valid,
    output logic                     rd_err,
    output logic                     wr_err,
    output logic [NUM_CTRL*DW-1:0]   ctrl_out,
    input  logic [NUM_STAT*DW-1:0]   stat_in,
    input  logic [NUM_EVT-1:0]       evt_in,
    output logic                     irq
);

    // ------------------------------------------------------------------ decode
    logic [AW-1:0]       w_ofs;
    logic [NUM_CTRL-1:0] w_ctrl_hit;
    logic [NUM_STAT-1:0] w_stat_hit;
    logic                w_sticky_hit;
    logic                w_en_hit;
    logic                w_raw_hit;
    logic                w_wr_ok;

    // Word-aligned offset; the low two address bits are don't-care.
    assign w_ofs = addr & ~AW'(3);

    always_comb begin
        for (int i = 0; i < NUM_CTRL; i++) begin
            w_ctrl_hit[i] = (w_ofs == AW'(CTRL_BASE + 4 * i));
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            w_stat_hit[j] = (w_ofs == AW'(STAT_BASE + 4 * j));
        end
    end

    assign w_sticky_hit = (w_ofs == AW'(EVT_STICKY_OFS));
    assign w_en_hit     = (w_ofs == AW'(EVT_EN_OFS));
    assign w_raw_hit    = (w_ofs == AW'(EVT_RAW_OFS));
    // A write with no byte enables is a no-op and never an error.
    assign w_wr_ok      = wr_en && (wr_be != '0);

    // --------------------------------------------------------- control regs
    logic [DW-1:0] w_ctrl_vec [NUM_CTRL];

    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
        logic [DW-1:0] r_ctrl;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ctrl <= CTRL_RST[gi*DW +: DW];
            end else if (w_wr_ok && w_ctrl_hit[gi]) begin
                for (int k = 0; k < DW/8; k++) begin
                    r_ctrl[k*8 +: 8] <= be_merge(r_ctrl[k*8 +: 8], wr_data[k*8 +: 8], wr_be[k]);
                end
            end
        end
        assign w_ctrl_vec[gi]          = r_ctrl;
        assign ctrl_out[gi*DW +: DW]   = r_ctrl;
    end

    // ---------------------------------------------------------- status regs
    logic [DW-1:0] w_stat_vec [NUM_STAT];

    for (genvar gj = 0; gj < NUM_STAT; gj++) begin : g_stat
        logic [DW-1:0] r_stat;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stat <= '0;
            end else begin
                r_stat <= stat_in[gj*DW +: DW];
            end
        end
        assign w_stat_vec[gj] = r_stat;
    end

    // --------------------------------------------------------------- events
    logic [NUM_EVT-1:0] w_evt_lvl;
    logic [NUM_EVT-1:0] w_evt_rise;
    logic [NUM_EVT-1:0] w_clr;
    logic [NUM_EVT-1:0] w_en_nxt;
    logic [NUM_EVT-1:0] r_sticky;
    logic [NUM_EVT-1:0] r_en;
    logic               r_irq;

    mfunc_evt_sync #(
        .NUM_EVT  (NUM_EVT),
        .SYNC_STG (SYNC_STG)
    ) u_evt_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt_in   (evt_in),
        .evt_lvl  (w_evt_lvl),
        .evt_rise (w_evt_rise)
    );

    // Bit b lives in byte lane b/8; bits at or above NUM_EVT do not exist.
    always_comb begin
        for (int b = 0; b < NUM_EVT; b++) begin
            w_clr[b]    = w_wr_ok && w_sticky_hit && wr_be[b/8] && wr_data[b];
            w_en_nxt[b] = (w_wr_ok && w_en_hit && wr_be[b/8]) ? wr_data[b] : r_en[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
            r_en     <= '0;
            r_irq    <= 1'b0;
        end else begin
            // OR-ing the rise after the clear makes a same-cycle set win.
            r_sticky <= (r_sticky & ~w_clr) | w_evt_rise;
            r_en     <= w_en_nxt;
            r_irq    <= |(r_sticky & r_en);
        end
    end

    assign irq = r_irq;

    // ------------------------------------------------------------ read path
    logic [DW-1:0] w_rd_val;
    logic          w_rd_hit;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_rd_err;
    logic          r_wr_err;

    always_comb begin
        w_rd_val = '0;
        w_rd_hit = 1'b0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (w_ctrl_hit[i]) begin
                w_rd_val = w_ctrl_vec[i];
                w_rd_hit = 1'b1;
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (w_stat_hit[j]) begin
                w_rd_val = w_stat_vec[j];
                w_rd_hit = 1'b1;
            end
        end
        if (w_sticky_hit) begin
            w_rd_val[NUM_EVT-1:0] = r_sticky;
            w_rd_hit              = 1'b1;
        end
        if (w_en_hit) begin
            w_rd_val[NUM_EVT-1:0] = r_en;
            w_rd_hit              = 1'b1;
        end
        if (w_raw_hit) begin
            w_rd_val[NUM_EVT-1:0] = w_evt_lvl;
            w_rd_hit              = 1'b1;
        end
    end

    // Read data is sampled from current state, so a same-cycle write to the
    // same address returns the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_err   <= rd_en && !w_rd_hit;
            if (rd_en) begin
                r_rd_data <= w_rd_val;
            end
            r_wr_err   <= w_wr_ok && !((|w_ctrl_hit) || w_sticky_hit || w_en_hit);
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;
    assign wr_err   = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_mfunc_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mfunc_reg_bank
//  Description : Scoreboard bench for mfunc_reg_bank. Reads push expected
//                responses into a queue; a negedge monitor pops and compares
//                whenever rd_valid is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mfunc_reg_bank;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NC = 4;
    localparam int NS = 2;
    localparam int NE = 8;
    localparam int SS = 2;
    localparam logic [NC*DW-1:0] C_CRST = {32'h3, 32'h2, 32'h1, 32'h0};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [DW/8-1:0]   wr_be;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wr_data;
    logic              rd_en;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              wr_err;
    logic [NC*DW-1:0]  ctrl_out;
    logic [NS*DW-1:0]  stat_in;
    logic [NE-1:0]     evt_in;
    logic              irq;

    mfunc_reg_bank #(
        .DW (DW), .AW (AW), .NUM_CTRL (NC), .NUM_STAT (NS),
        .NUM_EVT (NE), .SYNC_STG (SS), .CTRL_RST (C_CRST)
    ) dut (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_be (wr_be),
        .addr (addr), .wr_data (wr_data), .rd_en (rd_en), .rd_data (rd_data),
        .rd_valid (rd_valid), .rd_err (rd_err), .wr_err (wr_err),
        .ctrl_out (ctrl_out), .stat_in (stat_in), .evt_in (evt_in), .irq (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [11:0] a;
    } exp_t;
    exp_t exp_q[$];

    // Reference model of the programmer-visible state.
    logic [31:0] m_ctrl [NC];
    logic [31:0] m_stat [NS];
    logic [7:0]  m_sticky;
    logic [7:0]  m_en;
    logic [7:0]  m_raw;
    logic [31:0] st0, st1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_ctrl[i] = 32'(i);
        for (int j = 0; j < NS; j++) m_stat[j] = '0;
        m_sticky = '0;
        m_en     = '0;
        m_raw    = '0;
    endtask

    function automatic void exp_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        logic [11:0] w;
        w = a & 12'hffc;
        d = '0;
        e = 1'b0;
        if (w < 12'h010)                    d = m_ctrl[w[3:2]];
        else if (w == 12'h020 || w == 12'h024) d = m_stat[w[2]];
        else if (w == 12'h040)              d = {24'h0, m_sticky};
        else if (w == 12'h044)              d = {24'h0, m_en};
        else if (w == 12'h048)              d = {24'h0, m_raw};
        else                                e = 1'b1;
    endfunction

    // One bus cycle: drive, predict, advance one clock, check registered outputs.
    task automatic cyc(input bit we, input logic [3:0] be, input logic [11:0] a,
                       input logic [31:0] wd, input bit re);
        logic [31:0] d;
        logic        e;
        logic [11:0] w;
        logic        exp_werr;
        logic        exp_irq;
        wr_en   = we;
        wr_be   = be;
        addr    = a;
        wr_data = wd;
        rd_en   = re;
        stat_in = {st1, st0};
        w = a & 12'hffc;
        if (re) begin
            exp_read(a, d, e);
            exp_q.push_back('{data: d, err: e, a: a});
        end
        exp_irq  = |(m_sticky & m_en);
        exp_werr = we && (be != 4'h0) && !(w < 12'h010 || w == 12'h040 || w == 12'h044);
        if (we && be != 4'h0) begin
            if (w < 12'h010) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) m_ctrl[w[3:2]][k*8 +: 8] = wd[k*8 +: 8];
            end else if (w == 12'h040) begin
                if (be[0]) m_sticky = m_sticky & ~wd[7:0];
            end else if (w == 12'h044) begin
                if (be[0]) m_en = wd[7:0];
            end
        end
        m_stat[0] = st0;
        m_stat[1] = st1;
        @(posedge clk);
        #1;
        chk("wr_err", 128'(wr_err), 128'(exp_werr));
        chk("irq", 128'(irq), 128'(exp_irq));
        chk("ctrl_out", 128'(ctrl_out), {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [11:0] a);
        cyc(1'b0, 4'h0, a, 32'h0, 1'b1);
    endtask

    task automatic wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd);
        cyc(1'b1, be, a, wd, 1'b0);
    endtask

    // Monitor: compares every presented read response against the scoreboard.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%h expected no response", rd_data);
            end else begin
                exp_t ex;
                ex = exp_q.pop_front();
                chk($sformatf("rd_data@%h", ex.a), 128'(rd_data), 128'(ex.data));
                chk($sformatf("rd_err@%h", ex.a), 128'(rd_err), 128'(ex.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [11:0] addr_tbl [14] = '{12'h000, 12'h004, 12'h008, 12'h00c, 12'h010,
                                   12'h020, 12'h024, 12'h028, 12'h040, 12'h044,
                                   12'h048, 12'h04c, 12'h100, 12'hffc};

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_be = '0; addr = '0; wr_data = '0;
        rd_en = 1'b0; evt_in = '0;
        st0 = 32'h1234_5678; st1 = 32'h9abc_def0;
        stat_in = {st1, st0};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_irq", 128'(irq), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_rd_data", 128'(rd_data), 128'(0));
        chk("rst_wr_err", 128'(wr_err), 128'(0));
        chk("rst_ctrl_out", 128'(ctrl_out), 128'h00000003_00000002_00000001_00000000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) idle();
        rd(12'h000); rd(12'h004); rd(12'h008); rd(12'h00c);

        // Byte-lane write
        wr(12'h004, 4'b0101, 32'hAABBCCDD);
        rd(12'h004);
        chk("byte_wr_model", 128'(m_ctrl[1]), 128'h00BB00DD);

        // Errors and read-only handling
        rd(12'h100);
        wr(12'h020, 4'hf, 32'hdead_beef);
        rd(12'h020);
        wr(12'h020, 4'h0, 32'hdead_beef);
        wr(12'h048, 4'h1, 32'hff);
        wr(12'h008, 4'h0, 32'hffff_ffff);
        rd(12'h008);
        // Read of an address written in the same cycle returns the old value
        cyc(1'b1, 4'hf, 12'h00c, 32'h5a5a_a5a5, 1'b1);
        rd(12'h00e);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            st0 = $urandom;
            if ($urandom_range(0, 3) == 0) st1 = $urandom;
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                addr_tbl[$urandom_range(0, 13)] | 12'($urandom_range(0, 3)),
                $urandom, 1'($urandom_range(0, 1)));
        end
        repeat (2) idle();

        // Event path: latency SYNC_STG+1 to sticky, irq one clock later
        wr(12'h044, 4'hf, 32'h0000_0001);
        wr(12'h040, 4'hf, 32'hffff_ffff);
        repeat (4) idle();
        evt_in[0] = 1'b1;
        idle();
        evt_in[0] = 1'b0;
        rd(12'h040);
        rd(12'h040);
        m_sticky[0] = 1'b1;
        rd(12'h040);
        idle();
        // W1C clears, irq follows one clock later
        wr(12'h040, 4'hf, 32'h0000_0001);
        idle();
        rd(12'h040);

        // Raw level and an event that is not enabled
        evt_in[2] = 1'b1;
        repeat (3) idle();
        m_raw = 8'h04;
        m_sticky[2] = 1'b1;
        rd(12'h048);
        rd(12'h040);
        evt_in[2] = 1'b0;
        repeat (3) idle();
        m_raw = 8'h00;
        wr(12'h040, 4'h1, 32'h0000_0004);
        rd(12'h040);
        rd(12'h048);

        // Set/clear collision on bit 0: set wins
        evt_in[0] = 1'b1;
        idle();
        evt_in[0] = 1'b0;
        repeat (2) idle();
        m_sticky[0] = 1'b1;
        repeat (3) idle();
        evt_in[0] = 1'b1;
        idle();
        evt_in[0] = 1'b0;
        idle();
        wr(12'h040, 4'hf, 32'h0000_0001);
        m_sticky[0] = 1'b1;
        rd(12'h040);
        idle();

        // Asynchronous reset with a read in flight and a sticky bit set
        wr_en = 1'b0; rd_en = 1'b1; addr = 12'h000;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        rd_en = 1'b0;
        evt_in[1] = 1'b1;
        #1;
        chk("rst_drop_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_irq_async", 128'(irq), 128'(0));
        chk("rst_ctrl_async", 128'(ctrl_out), 128'h00000003_00000002_00000001_00000000);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) idle();
        m_raw = 8'h02;
        rd(12'h040);
        rd(12'h044);
        rd(12'h048);
        rd(12'h004);
        evt_in[1] = 1'b0;
        repeat (3) idle();

        // Drain the scoreboard
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
